mem_stage: RTL and testbench

- Pipeline MEM stage. Consumes the EX/MEM pipeline register outputs and performs the data-memory access over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Selects writeback data and registers it into the MEM/WB outputs that drive the register file write port.

---
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: performs the data-memory access over a req/ack handshake,
// stalls upstream while it is outstanding, and registers the MEM/WB results.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] PC_INC  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem,
  input  logic        rf_we_mem,
  input  logic        dram_we_mem,
  input  logic [1:0]  wd_sel_mem,
  input  logic [4:0]  wR_mem,
  input  logic [31:0] sext_mem,
  input  logic [31:0] pc_mem,
  input  logic [31:0] alu_c_mem,
  input  logic [31:0] rD2_mem,
  output logic        stall_mem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        valid_wb,
  output logic        rf_we_wb,
  output logic [4:0]  wR_wb,
  output logic [31:0] wD_wb,
  output logic [31:0] pc_wb,
  output logic        bus_err
);

  typedef enum logic {IDLE, REQ} state_e;

  // Counter only needs to reach TIMEOUT-1; it never runs past that while enabled.
  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam bit            TO_EN    = (TIMEOUT != 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc;
  logic          in_req;
  logic          timeout_hit;
  logic [31:0]   wd_d;

  logic          valid_wb_q, rf_we_wb_q, bus_err_q;
  logic [4:0]    wR_wb_q;
  logic [31:0]   wD_wb_q, pc_wb_q;

  always_comb begin
    acc         = valid_mem & (dram_we_mem | (wd_sel_mem == 2'b01));
    in_req      = (state_q == REQ);
    timeout_hit = TO_EN && in_req && (cnt_q == CNT_LAST) && !dm_ack;
    stall_mem   = acc & ~(in_req & (dm_ack | timeout_hit));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (dm_ack || timeout_hit) state_d = IDLE;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wd_d = alu_c_mem;
    case (wd_sel_mem)
      2'b00:   wd_d = alu_c_mem;
      2'b01:   wd_d = dm_rdata;
      2'b10:   wd_d = pc_mem + PC_INC;
      default: wd_d = sext_mem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stalled cycle retires as a bubble; payload fields hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_wb_q <= 1'b0;
      rf_we_wb_q <= 1'b0;
      wR_wb_q    <= '0;
      wD_wb_q    <= '0;
      pc_wb_q    <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (stall_mem) begin
        valid_wb_q <= 1'b0;
        rf_we_wb_q <= 1'b0;
      end else begin
        valid_wb_q <= valid_mem;
        rf_we_wb_q <= rf_we_mem & valid_mem & ~timeout_hit;
        wR_wb_q    <= wR_mem;
        wD_wb_q    <= wd_d;
        pc_wb_q    <= pc_mem;
      end
    end
  end

  assign dm_req   = in_req;
  assign dm_we    = dram_we_mem;
  assign dm_addr  = {alu_c_mem[31:2], 2'b00};
  assign dm_wdata = rD2_mem;

  assign valid_wb = valid_wb_q;
  assign rf_we_wb = rf_we_wb_q;
  assign wR_wb    = wR_wb_q;
  assign wD_wb    = wD_wb_q;
  assign pc_wb    = pc_wb_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): ALU/load/store/link/LUI writeback,
// wait states, timeout abort, back-to-back accesses and asynchronous reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem, rf_we_mem, dram_we_mem;
  logic [1:0]  wd_sel_mem;
  logic [4:0]  wR_mem;
  logic [31:0] sext_mem, pc_mem, alu_c_mem, rD2_mem;
  logic        stall_mem, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        valid_wb, rf_we_wb;
  logic [4:0]  wR_wb;
  logic [31:0] wD_wb, pc_wb;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4), .PC_INC(32'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_mem(valid_mem), .rf_we_mem(rf_we_mem), .dram_we_mem(dram_we_mem),
    .wd_sel_mem(wd_sel_mem), .wR_mem(wR_mem), .sext_mem(sext_mem),
    .pc_mem(pc_mem), .alu_c_mem(alu_c_mem), .rD2_mem(rD2_mem),
    .stall_mem(stall_mem), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .valid_wb(valid_wb), .rf_we_wb(rf_we_wb), .wR_wb(wR_wb),
    .wD_wb(wD_wb), .pc_wb(pc_wb), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid_mem = 0; rf_we_mem = 0; dram_we_mem = 0; wd_sel_mem = 2'b00;
    wR_mem = 0; sext_mem = 0; pc_mem = 0; alu_c_mem = 0; rD2_mem = 0;
    dm_ack = 0; dm_rdata = 0;
  endtask

  task automatic test_reset();
    checks++;
    if ({valid_wb, rf_we_wb, dm_req, stall_mem, bus_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {valid_wb, rf_we_wb, dm_req, stall_mem, bus_err});
    end
    checks++;
    if ({wR_wb, wD_wb, pc_wb} !== 69'b0) begin
      failures++;
      $display("FAIL reset_data wR=%0d wD=%h pc=%h exp=0", wR_wb, wD_wb, pc_wb);
    end
    $display("reset: valid_wb=%b dm_req=%b wD_wb=%h", valid_wb, dm_req, wD_wb);
  endtask

  task automatic test_alu();
    valid_mem = 1; rf_we_mem = 1; wd_sel_mem = 2'b00; alu_c_mem = 32'h1234; wR_mem = 5;
    pc_mem = 32'h40;
    #1;
    checks++;
    if (stall_mem !== 1'b0 || dm_req !== 1'b0) begin
      failures++;
      $display("FAIL alu_nostall stall=%b req=%b exp=0/0", stall_mem, dm_req);
    end
    tick();
    checks++;
    if ({valid_wb, rf_we_wb, wR_wb, wD_wb, pc_wb} !== {1'b1, 1'b1, 5'd5, 32'h1234, 32'h40}) begin
      failures++;
      $display("FAIL alu_wb v=%b we=%b wR=%0d wD=%h pc=%h exp=1/1/5/00001234/00000040",
               valid_wb, rf_we_wb, wR_wb, wD_wb, pc_wb);
    end
    $display("alu: wD_wb=%h wR_wb=%0d", wD_wb, wR_wb);
    set_idle();
  endtask

  task automatic test_load_0wait();
    valid_mem = 1; rf_we_mem = 1; wd_sel_mem = 2'b01; alu_c_mem = 32'h103; wR_mem = 7;
    #1;
    checks++;
    if (stall_mem !== 1'b1 || dm_req !== 1'b0) begin
      failures++;
      $display("FAIL load_idle stall=%b req=%b exp=1/0", stall_mem, dm_req);
    end
    tick();
    checks++;
    if ({dm_req, dm_we, dm_addr, valid_wb, rf_we_wb} !== {1'b1, 1'b0, 32'h100, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_req req=%b we=%b addr=%h vwb=%b wewb=%b exp=1/0/00000100/0/0",
               dm_req, dm_we, dm_addr, valid_wb, rf_we_wb);
    end
    dm_ack = 1; dm_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (stall_mem !== 1'b0) begin
      failures++;
      $display("FAIL load_ack_stall got=%b exp=0", stall_mem);
    end
    tick();
    checks++;
    if ({valid_wb, rf_we_wb, wR_wb, wD_wb, dm_req, bus_err} !== {1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_wb v=%b we=%b wR=%0d wD=%h req=%b err=%b exp=1/1/7/deadbeef/0/0",
               valid_wb, rf_we_wb, wR_wb, wD_wb, dm_req, bus_err);
    end
    $display("load0: wD_wb=%h", wD_wb);
    set_idle();
  endtask

  task automatic test_store_3wait();
    int req_n = 0;
    int stall_n = 0;
    int bus_bad = 0;
    valid_mem = 1; rf_we_mem = 0; dram_we_mem = 1; wd_sel_mem = 2'b00;
    alu_c_mem = 32'h200; rD2_mem = 32'hA5A5A5A5; wR_mem = 3;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) dm_ack = 1;
      #1;
      if (dm_req) begin
        req_n++;
        if (dm_we !== 1'b1 || dm_wdata !== 32'hA5A5A5A5 || dm_addr !== 32'h200) bus_bad++;
      end
      if (stall_mem) stall_n++;
      tick();
    end
    checks++;
    if (req_n != 4 || stall_n != 4) begin
      failures++;
      $display("FAIL store_cycles req=%0d stall=%0d exp=4/4", req_n, stall_n);
    end
    checks++;
    if (bus_bad != 0) begin
      failures++;
      $display("FAIL store_bus bad_cycles=%0d exp=0", bus_bad);
    end
    checks++;
    if ({valid_wb, rf_we_wb, dm_req, bus_err} !== 4'b1000) begin
      failures++;
      $display("FAIL store_retire v=%b we=%b req=%b err=%b exp=1000", valid_wb, rf_we_wb, dm_req, bus_err);
    end
    $display("store3: req_cycles=%0d stall_cycles=%0d", req_n, stall_n);
    set_idle();
  endtask

  task automatic test_link_lui();
    valid_mem = 1; rf_we_mem = 1; wd_sel_mem = 2'b10; pc_mem = 32'h80; wR_mem = 1;
    tick();
    checks++;
    if (wD_wb !== 32'h84 || pc_wb !== 32'h80 || rf_we_wb !== 1'b1) begin
      failures++;
      $display("FAIL jal_link wD=%h pc=%h we=%b exp=00000084/00000080/1", wD_wb, pc_wb, rf_we_wb);
    end
    $display("jal: wD_wb=%h", wD_wb);
    pc_mem = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (wD_wb !== 32'h0) begin
      failures++;
      $display("FAIL jal_wrap wD=%h exp=00000000", wD_wb);
    end
    wd_sel_mem = 2'b11; sext_mem = 32'h12345000; wR_mem = 9;
    tick();
    checks++;
    if (wD_wb !== 32'h12345000 || wR_wb !== 5'd9) begin
      failures++;
      $display("FAIL lui wD=%h wR=%0d exp=12345000/9", wD_wb, wR_wb);
    end
    $display("lui: wD_wb=%h", wD_wb);
    set_idle();
  endtask

  task automatic test_timeout();
    int req_n = 0;
    int stall_n = 0;
    valid_mem = 1; rf_we_mem = 1; wd_sel_mem = 2'b01; alu_c_mem = 32'h300; wR_mem = 4;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (dm_req) req_n++;
      if (stall_mem) stall_n++;
      tick();
    end
    checks++;
    if (req_n != 4 || stall_n != 4) begin
      failures++;
      $display("FAIL timeout_cycles req=%0d stall=%0d exp=4/4", req_n, stall_n);
    end
    checks++;
    if ({dm_req, bus_err, valid_wb, rf_we_wb} !== 4'b0110) begin
      failures++;
      $display("FAIL timeout_abort req=%b err=%b v=%b we=%b exp=0110", dm_req, bus_err, valid_wb, rf_we_wb);
    end
    set_idle();
    tick();
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse err=%b exp=0", bus_err);
    end
    $display("timeout: req_cycles=%0d", req_n);
  endtask

  task automatic test_ack_at_limit();
    valid_mem = 1; rf_we_mem = 1; wd_sel_mem = 2'b01; alu_c_mem = 32'h304; wR_mem = 6;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        dm_ack = 1; dm_rdata = 32'hCAFE0001;
      end
      tick();
    end
    checks++;
    if ({bus_err, valid_wb, rf_we_wb, dm_req} !== 4'b0110 || wD_wb !== 32'hCAFE0001) begin
      failures++;
      $display("FAIL ack_at_limit err=%b v=%b we=%b req=%b wD=%h exp=0/1/1/0/cafe0001",
               bus_err, valid_wb, rf_we_wb, dm_req, wD_wb);
    end
    $display("ack_at_limit: wD_wb=%h bus_err=%b", wD_wb, bus_err);
    set_idle();
  endtask

  task automatic test_back_to_back();
    valid_mem = 1; rf_we_mem = 1; wd_sel_mem = 2'b01; alu_c_mem = 32'h400; wR_mem = 10;
    tick();
    dm_ack = 1; dm_rdata = 32'h11111111;
    tick();
    checks++;
    if (wD_wb !== 32'h11111111 || rf_we_wb !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first wD=%h we=%b exp=11111111/1", wD_wb, rf_we_wb);
    end
    alu_c_mem = 32'h404; wR_mem = 11; dm_rdata = 32'h22222222;
    #1;
    checks++;
    if (dm_req !== 1'b0 || stall_mem !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap req=%b stall=%b exp=0/1", dm_req, stall_mem);
    end
    tick();
    checks++;
    if (dm_req !== 1'b1 || dm_addr !== 32'h404 || stall_mem !== 1'b0) begin
      failures++;
      $display("FAIL b2b_req2 req=%b addr=%h stall=%b exp=1/00000404/0", dm_req, dm_addr, stall_mem);
    end
    tick();
    checks++;
    if (wD_wb !== 32'h22222222 || wR_wb !== 5'd11) begin
      failures++;
      $display("FAIL b2b_second wD=%h wR=%0d exp=22222222/11", wD_wb, wR_wb);
    end
    $display("b2b: second wD_wb=%h", wD_wb);
    set_idle();
  endtask

  task automatic test_reset_mid_req();
    int spurious = 0;
    valid_mem = 1; rf_we_mem = 1; wd_sel_mem = 2'b01; alu_c_mem = 32'h500; wR_mem = 12;
    pc_mem = 32'h900;
    tick();
    tick();
    checks++;
    if (dm_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre req=%b exp=1", dm_req);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({dm_req, valid_wb, rf_we_wb, bus_err} !== 4'b0 || {wR_wb, wD_wb, pc_wb} !== 69'b0) begin
      failures++;
      $display("FAIL rstmid_clear req=%b v=%b we=%b err=%b wR=%0d wD=%h pc=%h exp=all0",
               dm_req, valid_wb, rf_we_wb, bus_err, wR_wb, wD_wb, pc_wb);
    end
    set_idle();
    tick();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dm_req !== 1'b0 || stall_mem !== 1'b0 || valid_wb !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL rstmid_after spurious_cycles=%0d exp=0", spurious);
    end
    $display("reset_mid_req: dm_req=%b valid_wb=%b", dm_req, valid_wb);
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    tick();
    test_alu();
    test_load_0wait();
    test_store_3wait();
    test_link_lui();
    test_timeout();
    test_ack_at_limit();
    test_back_to_back();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
